aes_word_bridge: RTL and testbench
==================================

// Module: aes_word_bridge
// PURPOSE
//  Upstream/downstream host bridge for aes_main on a 32-bit word stream.
//  - Assembles key or plaintext words into the 256-bit aes_main data bus.
//  - Holds all aes_main inputs stable and sequences start/ready.
//  - Returns the 128-bit result as 4 words on a valid/ready stream.
// PARAMETERS
//  WORD_W   32   stream word width; fixed at 32; other values are unsupported
//  DATA_W   256  aes_main data bus width
//  BLOCK_W  128  AES block / result width
// PORTS
//  clk            in   1    single clock; everything is posedge clk
//  rst            in   1    synchronous, active-high reset; same net as aes_main rst
//  cmd_valid      in   1    command offer
//  cmd_ready      out  1    command accepted when cmd_valid & cmd_ready
//  cmd_key        in   1    1 = key load; 0 = data block
//  cmd_key_len    in   2    00=128, 01=192, 10=256, 11=reserved
//  cmd_encrypt    in   1    encrypt_decrypt value for a data command
//  in_valid       in   1    word offer
//  in_ready       out  1    word accepted when in_valid & in_ready
//  in_data        in   32   key/plaintext word, most-significant word first
//  out_valid      out  1    result word valid
//  out_ready      in   1    downstream accepts the word
//  out_data       out  32   result word, most-significant word first
//  out_last       out  1    high with the 4th result word
//  aes_start      out  1    to aes_main start
//  aes_key_data   out  1    to aes_main key_data (1 = data, 0 = key)
//  aes_key_length out  2    to aes_main key_length
//  aes_encrypt    out  1    to aes_main encrypt_decrypt
//  aes_data       out  256  to aes_main data
//  aes_result     in   128  from aes_main result
//  aes_ready      in   1    from aes_main ready (high = idle)
// BEHAVIOUR
//  Reset values: all outputs 0, except cmd_ready = 1. State = IDLE; word counter = 0.
//  States: IDLE -> LOAD -> START -> WAIT_BUSY -> WAIT_DONE -> (DRAIN | IDLE)
//  IDLE: cmd_ready = 1. On cmd handshake, latch cmd_key/len/encrypt:
//    - aes_key_data = ~cmd_key
//    - nwords = 4, 6 or 8 for key lengths 00/01/10; 11 loads 8 and passes the code through
//    - data commands always load 4 words
//    Clear aes_data to 0, then go to LOAD.
//  LOAD: in_ready = 1. Word i (0-based) is written to aes_data[32*(nwords-1-i) +: 32],
//    right-aligned, so data words fill [127:0]. After the last word, go to START.
//  START: aes_start = 1 for exactly 1 cycle, issued only when aes_ready = 1;
//    otherwise hold in START. Then go to WAIT_BUSY.
//  WAIT_BUSY: wait for aes_ready = 0, then go to WAIT_DONE.
//  WAIT_DONE: wait for aes_ready = 1.
//    - Key command: go to IDLE; no output words.
//    - Data command: capture aes_result into a 128-bit register and go to DRAIN.
//  DRAIN: out_valid = 1; words [127:96], [95:64], [63:32], [31:0] in order.
//    - Advance only on out_valid & out_ready; out_data is stable while stalled.
//    - out_last = 1 on word 3. Its handshake returns to IDLE.
//  Stability: aes_data, aes_key_data, aes_key_length and aes_encrypt are held
//    unchanged from START until the FSM leaves WAIT_DONE.
//  cmd_ready = 0 outside IDLE. in_ready = 0 outside LOAD. No words are accepted early.
//  Minimum latency: cmd handshake to first out_valid = 4 LOAD cycles + 1 START
//    + aes_main busy time + 1 capture cycle.
//  Reset mid-operation: returns to IDLE next edge. Partial words are discarded.
//    A pending output is dropped and out_valid falls to 0.
//  aes_main key length is latched by its key expander only on key loads.
//    aes_key_length carries the last key command's code; data commands do not alter it.
// STRUCTURE
//  aes_pkg:
//    - typedef enum logic [1:0] aes_klen_t {KLEN_128, KLEN_192, KLEN_256, KLEN_RSVD}
//    - function klen_words(aes_klen_t) returning 4/6/8/8
//    - localparams WORD_W, DATA_W, BLOCK_W
//  Sub-module aes_result_serializer: 128-bit capture register, 2-bit index,
//    valid/ready/last output. The parent keeps the load/sequence FSM.
// TESTING
//  1. FIPS-197 vectors, key 000102..0f.
//     - Key command, len 00, words 00010203 04050607 08090a0b 0c0d0e0f
//       -> 1 aes_start pulse, aes_key_data = 0, no out_valid.
//     - Data command, encrypt, words 00112233 44556677 8899aabb ccddeeff
//       -> out 69c4e0d8 6a7b0430 d8cdb780 70b4c55a, out_last on the 4th.
//  2. Decrypt with the same key: input 69c4e0d8..70b4c55a -> out 00112233..ccddeeff.
//  3. 256-bit key, len 10, words 00010203..1c1d1e1f
//     -> aes_data = 000102..1f; data 00112233.. -> out 8ea2b7ca 516745bf eafc4990 4b496089.
//  4. out_ready low for 5 cycles after word 1
//     -> out_data holds 6a7b0430 with out_valid high, no word is lost; next command blocked.
//  5. aes_ready held 0 in START for 3 cycles
//     -> aes_start stays 0 until aes_ready = 1, then is high for exactly 1 cycle.
//  6. rst after 2 of 4 data words
//     -> next cycle state IDLE, cmd_ready = 1, aes_start = 0.
//     -> A new 4-word block encrypts correctly.

Source files
------------

// File: rtl/aes_word_bridge_pkg.sv
// Shared types and widths for the aes_main word-stream bridge.
package aes_pkg;
  localparam int WORD_W  = 32;
  localparam int DATA_W  = 256;
  localparam int BLOCK_W = 128;

  typedef enum logic [1:0] {KLEN_128, KLEN_192, KLEN_256, KLEN_RSVD} aes_klen_t;

  typedef enum logic [2:0] {
    ST_IDLE, ST_LOAD, ST_START, ST_WAIT_BUSY, ST_WAIT_DONE, ST_DRAIN
  } bridge_state_t;

  // The reserved code still loads a full 256-bit key worth of words.
  function automatic logic [3:0] klen_words(aes_klen_t klen);
    case (klen)
      KLEN_128: return 4'd4;
      KLEN_192: return 4'd6;
      default:  return 4'd8;
    endcase
  endfunction
endpackage

// File: rtl/aes_word_bridge_if.sv
// Host-side command, input-word and result-word streams of the bridge.
interface aes_word_bridge_if;
  import aes_pkg::*;
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_key;
  logic [1:0]        cmd_key_len;
  logic              cmd_encrypt;
  logic              in_valid;
  logic              in_ready;
  logic [WORD_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [WORD_W-1:0] out_data;
  logic              out_last;

  modport slave (
    input  cmd_valid, cmd_key, cmd_key_len, cmd_encrypt, in_valid, in_data, out_ready,
    output cmd_ready, in_ready, out_valid, out_data, out_last
  );
  modport master (
    output cmd_valid, cmd_key, cmd_key_len, cmd_encrypt, in_valid, in_data, out_ready,
    input  cmd_ready, in_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/aes_word_bridge_serializer.sv
// Captures the 128-bit aes_main result and streams it out MS word first.
module aes_result_serializer
  import aes_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [BLOCK_W-1:0] result,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WORD_W-1:0]  out_data,
  output logic               out_last
);
  logic [BLOCK_W-1:0] block;
  logic [1:0]         idx;
  logic [1:0]         sel;

  always_ff @(posedge clk) begin
    if (rst) begin
      block     <= '0;
      idx       <= '0;
      out_valid <= 1'b0;
    end else if (load) begin
      block     <= result;
      idx       <= '0;
      out_valid <= 1'b1;
    end else if (out_valid && out_ready) begin
      idx <= idx + 2'd1;
      if (idx == 2'd3) out_valid <= 1'b0;
    end
  end

  // Word 0 is the most-significant slice, so the slice select runs backwards.
  assign sel      = ~idx;
  assign out_data = block[WORD_W*sel +: WORD_W];
  assign out_last = out_valid && (idx == 2'd3);
endmodule

// File: rtl/aes_word_bridge.sv
// Host bridge for aes_main: loads key/data words, sequences start/ready, drains result.
module aes_word_bridge
  import aes_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  aes_word_bridge_if.slave   host,
  output logic               aes_start,
  output logic               aes_key_data,
  output logic [1:0]         aes_key_length,
  output logic               aes_encrypt,
  output logic [DATA_W-1:0]  aes_data,
  input  logic [BLOCK_W-1:0] aes_result,
  input  logic               aes_ready
);
  bridge_state_t state, state_nxt;
  logic [3:0] nwords;
  logic [2:0] cnt;
  logic [2:0] widx;
  logic       is_key;
  logic       cmd_fire, in_fire, last_word, out_done, capture;

  assign cmd_fire  = host.cmd_valid && host.cmd_ready;
  assign in_fire   = host.in_valid && host.in_ready;
  assign last_word = ({1'b0, cnt} == (nwords - 4'd1));
  assign widx      = 3'(nwords - 4'd1 - {1'b0, cnt});
  assign out_done  = host.out_valid && host.out_ready && host.out_last;

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:      if (cmd_fire) state_nxt = ST_LOAD;
      ST_LOAD:      if (in_fire && last_word) state_nxt = ST_START;
      ST_START:     if (aes_ready) state_nxt = ST_WAIT_BUSY;
      ST_WAIT_BUSY: if (!aes_ready) state_nxt = ST_WAIT_DONE;
      ST_WAIT_DONE: if (aes_ready) state_nxt = is_key ? ST_IDLE : ST_DRAIN;
      ST_DRAIN:     if (out_done) state_nxt = ST_IDLE;
      default:      state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    host.cmd_ready = (state == ST_IDLE);
    host.in_ready  = (state == ST_LOAD);
    aes_start      = (state == ST_START) && aes_ready;
    capture        = (state == ST_WAIT_DONE) && aes_ready && !is_key;
  end

  // aes_main inputs only change in IDLE/LOAD, so they hold from START through WAIT_DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      aes_data       <= '0;
      aes_key_data   <= 1'b0;
      aes_key_length <= 2'b00;
      aes_encrypt    <= 1'b0;
      nwords         <= 4'd0;
      cnt            <= 3'd0;
      is_key         <= 1'b0;
    end else begin
      if (cmd_fire) begin
        is_key       <= host.cmd_key;
        aes_key_data <= ~host.cmd_key;
        aes_data     <= '0;
        cnt          <= 3'd0;
        if (host.cmd_key) begin
          aes_key_length <= host.cmd_key_len;
          nwords         <= klen_words(aes_klen_t'(host.cmd_key_len));
        end else begin
          aes_encrypt <= host.cmd_encrypt;
          nwords      <= 4'd4;
        end
      end
      if (in_fire) begin
        aes_data[WORD_W*widx +: WORD_W] <= host.in_data;
        cnt <= cnt + 3'd1;
      end
    end
  end

  aes_result_serializer u_ser (
    .clk       (clk),
    .rst       (rst),
    .load      (capture),
    .result    (aes_result),
    .out_valid (host.out_valid),
    .out_ready (host.out_ready),
    .out_data  (host.out_data),
    .out_last  (host.out_last)
  );
endmodule

// File: tb/tb_aes_word_bridge.sv
// Directed bench for aes_word_bridge with a table-driven aes_main stand-in.
module tb_aes_word_bridge;
  logic clk = 1'b0;
  logic rst = 1'b1;
  aes_word_bridge_if bus();
  logic         aes_start, aes_key_data, aes_encrypt, aes_ready;
  logic [1:0]   aes_key_length;
  logic [255:0] aes_data;
  logic [127:0] aes_result;

  localparam logic [255:0] K128  = 256'h000102030405060708090a0b0c0d0e0f;
  localparam logic [255:0] K256  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] PT    = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT256 = 128'h8ea2b7ca516745bfeafc49904b496089;

  int compared = 0;
  int mismatched = 0;
  int starts = 0;
  int ovalid = 0;

  always #5 clk = ~clk;

  aes_word_bridge dut (
    .clk(clk), .rst(rst), .host(bus),
    .aes_start(aes_start), .aes_key_data(aes_key_data), .aes_key_length(aes_key_length),
    .aes_encrypt(aes_encrypt), .aes_data(aes_data), .aes_result(aes_result), .aes_ready(aes_ready)
  );

  // aes_main stand-in: known FIPS-197 answers, anything else returns the inverted block.
  function automatic logic [127:0] model(input logic [255:0] k, input logic [1:0] kl,
                                         input logic enc, input logic [127:0] b);
    if (k === K128 && kl == 2'b00 && enc && b === PT) return CT128;
    if (k === K128 && kl == 2'b00 && !enc && b === CT128) return PT;
    if (k === K256 && kl == 2'b10 && enc && b === PT) return CT256;
    return ~b;
  endfunction

  logic         stub_ready, hold;
  logic [2:0]   busy;
  logic [255:0] key_reg;
  logic [1:0]   klen_reg;
  assign aes_ready = stub_ready & ~hold;

  always @(posedge clk) begin
    if (rst) begin
      stub_ready <= 1'b1;
      busy       <= 3'd0;
    end else if (aes_start && aes_ready) begin
      stub_ready <= 1'b0;
      busy       <= 3'd3;
      if (!aes_key_data) begin
        key_reg  <= aes_data;
        klen_reg <= aes_key_length;
      end else begin
        aes_result <= model(key_reg, klen_reg, aes_encrypt, aes_data[127:0]);
      end
    end else if (!stub_ready) begin
      busy <= busy - 3'd1;
      if (busy == 3'd1) stub_ready <= 1'b1;
    end
  end

  always @(posedge clk) begin
    if (!rst) begin
      if (aes_start) starts <= starts + 1;
      if (bus.out_valid) ovalid <= ovalid + 1;
    end
  end

  task automatic send_cmd(input logic key, input logic [1:0] len, input logic enc);
    int t = 0;
    bus.cmd_valid = 1'b1; bus.cmd_key = key; bus.cmd_key_len = len; bus.cmd_encrypt = enc;
    while (!bus.cmd_ready && t < 200) begin @(posedge clk); #1; t++; end
    compared++;
    if (!bus.cmd_ready) begin
      mismatched++;
      $display("FAIL cmd_accept cmd_ready=%b required=1", bus.cmd_ready);
    end
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
  endtask

  // Word i of an n-word load is taken from words[32*(n-1-i) +: 32].
  task automatic send_words(input logic [255:0] words, input int n);
    for (int i = 0; i < n; i++) begin
      int t = 0;
      bus.in_valid = 1'b1;
      bus.in_data  = words[32*(n-1-i) +: 32];
      while (!bus.in_ready && t < 200) begin @(posedge clk); #1; t++; end
      compared++;
      if (!bus.in_ready) begin
        mismatched++;
        $display("FAIL word_accept in_ready=%b required=1", bus.in_ready);
      end
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic recv_words(input int n, output logic [127:0] data, output logic [3:0] lasts);
    data = '0; lasts = '0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      int t = 0;
      while (!bus.out_valid && t < 200) begin @(posedge clk); #1; t++; end
      compared++;
      if (!bus.out_valid) begin
        mismatched++;
        $display("FAIL out_wait out_valid=%b required=1", bus.out_valid);
      end
      data[127-32*i -: 32] = bus.out_data;
      lasts[i] = bus.out_last;
      @(posedge clk); #1;
    end
  endtask

  task automatic wait_idle();
    int t = 0;
    while (!bus.cmd_ready && t < 200) begin @(posedge clk); #1; t++; end
    compared++;
    if (!bus.cmd_ready) begin
      mismatched++;
      $display("FAIL idle_wait cmd_ready=%b required=1", bus.cmd_ready);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    compared++;
    if ({bus.cmd_ready, bus.in_ready, bus.out_valid, bus.out_last, aes_start, aes_key_data, aes_encrypt}
        !== 7'b1000000) begin
      mismatched++;
      $display("FAIL reset_ctrl got=%b required=1000000",
               {bus.cmd_ready, bus.in_ready, bus.out_valid, bus.out_last, aes_start, aes_key_data, aes_encrypt});
    end
    compared++;
    if (aes_data !== '0 || aes_key_length !== 2'b00 || bus.out_data !== 32'h0) begin
      mismatched++;
      $display("FAIL reset_data aes_data=%h klen=%b out_data=%h required zero", aes_data, aes_key_length, bus.out_data);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_key128();
    int s0 = starts, v0 = ovalid;
    send_cmd(1'b1, 2'b00, 1'b0);
    send_words(K128, 4);
    wait_idle();
    compared++;
    if (starts - s0 !== 1) begin mismatched++; $display("FAIL key128_starts got=%0d required=1", starts - s0); end
    compared++;
    if (aes_key_data !== 1'b0) begin mismatched++; $display("FAIL key128_keydata got=%b required=0", aes_key_data); end
    compared++;
    if (aes_data !== K128) begin mismatched++; $display("FAIL key128_data got=%h required=%h", aes_data, K128); end
    compared++;
    if (ovalid !== v0) begin mismatched++; $display("FAIL key128_noout got=%0d required=%0d", ovalid, v0); end
  endtask

  task automatic test_block(input string name, input logic enc, input logic [127:0] blk,
                            input logic [127:0] expect_out);
    logic [127:0] d;
    logic [3:0]   l;
    send_cmd(1'b0, 2'b00, enc);
    send_words({128'h0, blk}, 4);
    recv_words(4, d, l);
    compared++;
    if (d !== expect_out) begin mismatched++; $display("FAIL %s_out got=%h required=%h", name, d, expect_out); end
    compared++;
    if (l !== 4'b1000) begin mismatched++; $display("FAIL %s_last got=%b required=1000", name, l); end
    compared++;
    if (aes_key_data !== 1'b1 || aes_encrypt !== enc) begin
      mismatched++;
      $display("FAIL %s_ctrl key_data=%b encrypt=%b required 1/%b", name, aes_key_data, aes_encrypt, enc);
    end
  endtask

  task automatic test_key256();
    send_cmd(1'b1, 2'b10, 1'b0);
    send_words(K256, 8);
    wait_idle();
    compared++;
    if (aes_data !== K256) begin mismatched++; $display("FAIL key256_data got=%h required=%h", aes_data, K256); end
    test_block("enc256", 1'b1, PT, CT256);
    compared++;
    if (aes_key_length !== 2'b10) begin mismatched++; $display("FAIL key256_len got=%b required=10", aes_key_length); end
  endtask

  task automatic test_out_stall();
    logic [127:0] d;
    logic [3:0]   l;
    int t = 0;
    send_cmd(1'b1, 2'b00, 1'b0);
    send_words(K128, 4);
    wait_idle();
    send_cmd(1'b0, 2'b00, 1'b1);
    send_words({128'h0, PT}, 4);
    bus.out_ready = 1'b1;
    while (!bus.out_valid && t < 200) begin @(posedge clk); #1; t++; end
    compared++;
    if (bus.out_data !== 32'h69c4e0d8) begin mismatched++; $display("FAIL stall_w0 got=%h required=69c4e0d8", bus.out_data); end
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    bus.cmd_valid = 1'b1; bus.cmd_key = 1'b0;
    for (int i = 0; i < 5; i++) begin
      compared++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h6a7b0430 || bus.cmd_ready !== 1'b0) begin
        mismatched++;
        $display("FAIL stall_hold cyc=%0d valid=%b data=%h cmd_ready=%b required 1/6a7b0430/0",
                 i, bus.out_valid, bus.out_data, bus.cmd_ready);
      end
      @(posedge clk); #1;
    end
    bus.cmd_valid = 1'b0;
    recv_words(3, d, l);
    compared++;
    if (d !== {96'h6a7b0430_d8cdb780_70b4c55a, 32'h0} || l !== 4'b0100) begin
      mismatched++;
      $display("FAIL stall_rest got=%h last=%b required=6a7b0430d8cdb78070b4c55a00000000/0100", d, l);
    end
  endtask

  task automatic test_start_hold();
    logic [127:0] d;
    logic [3:0]   l;
    int s0;
    hold = 1'b1;
    send_cmd(1'b0, 2'b00, 1'b1);
    send_words({128'h0, PT}, 4);
    s0 = starts;
    for (int i = 0; i < 3; i++) begin
      compared++;
      if (aes_start !== 1'b0) begin mismatched++; $display("FAIL hold_start cyc=%0d got=%b required=0", i, aes_start); end
      @(posedge clk); #1;
    end
    hold = 1'b0;
    #1;
    compared++;
    if (aes_start !== 1'b1) begin mismatched++; $display("FAIL hold_release got=%b required=1", aes_start); end
    @(posedge clk); #1;
    compared++;
    if (aes_start !== 1'b0) begin mismatched++; $display("FAIL hold_pulse got=%b required=0", aes_start); end
    recv_words(4, d, l);
    compared++;
    if (d !== CT128 || starts - s0 !== 1) begin
      mismatched++;
      $display("FAIL hold_out got=%h starts=%0d required=%h/1", d, starts - s0, CT128);
    end
  endtask

  task automatic test_reset_mid();
    send_cmd(1'b0, 2'b00, 1'b1);
    send_words({192'h0, PT[127:64]}, 2);
    rst = 1'b1;
    @(posedge clk); #1;
    compared++;
    if ({bus.cmd_ready, bus.in_ready, aes_start, bus.out_valid} !== 4'b1000) begin
      mismatched++;
      $display("FAIL midrst_ctrl got=%b required=1000", {bus.cmd_ready, bus.in_ready, aes_start, bus.out_valid});
    end
    rst = 1'b0;
    @(posedge clk); #1;
    test_block("after_rst", 1'b1, PT, CT128);
  endtask

  initial begin
    bus.cmd_valid = 1'b0; bus.cmd_key = 1'b0; bus.cmd_key_len = 2'b00; bus.cmd_encrypt = 1'b0;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
    hold = 1'b0;
    test_reset();
    test_key128();
    test_block("enc128", 1'b1, PT, CT128);
    test_block("dec128", 1'b0, CT128, PT);
    test_key256();
    test_out_stall();
    test_start_hold();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
